// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared pixel width and column metadata types for the convolution engine
package conv_pkg;

    localparam int PIXEL_W = 8;
    localparam int KMAX    = 9;
    localparam int XW      = 16;

    typedef struct packed {
        logic            sol;
        logic            eol;
        logic [XW-1:0]   x;
        logic [KMAX-1:0] row_vld;
    } col_meta_t;

endpackage

// File: rtl/conv_lb_bank.sv
// rtl/conv_lb_bank.sv - single-port read-first synchronous line-buffer bank
module conv_lb_bank
    import conv_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic [PIXEL_W-1:0] wdata,
    output logic [PIXEL_W-1:0] rdata
);

    logic [PIXEL_W-1:0] mem [DEPTH];

    // Read-first: the word being replaced is what comes out.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/conv_col_gen.sv
// rtl/conv_col_gen.sv - raster-to-column generator: K-1 rotating line banks, position tracking,
// line-length checking and a one-deep output register.
module conv_col_gen
    import conv_pkg::*;
#(
    parameter int   K           = 5,
    parameter int   MAX_W       = 1024,
    parameter logic BORDER_ZERO = 1'b0
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     s_tvalid_i,
    input  logic [PIXEL_W-1:0]       s_tdata_i,
    input  logic                     s_tuser_i,
    input  logic                     s_tlast_i,
    output logic                     s_tready_o,
    output logic                     m_tvalid_o,
    input  logic                     m_tready_i,
    output logic [K*PIXEL_W-1:0]     m_col_data_o,
    output logic [K-1:0]             m_col_row_vld_o,
    output logic                     m_col_sol_o,
    output logic                     m_col_eol_o,
    output logic [$clog2(MAX_W)-1:0] m_col_x_o,
    output logic                     err_len_o
);

    localparam int XB = $clog2(MAX_W);
    localparam int NB = K - 1;

    logic               accept;
    logic [XB-1:0]      x_q, x_cur;
    logic [XB:0]        len_cur, w_q;
    logic [NB-1:0]      row_vld_q, row_cur;
    logic [NB-1:0]      rot_q, rot_cur, rot_out_q;
    logic               sat_q, sat_cur;
    logic               w_known_q, w_known_cur;
    logic               at_max, ovf, len_bad;
    logic [PIXEL_W-1:0] tap0_q;
    logic [PIXEL_W-1:0] rd_data [NB];

    assign s_tready_o = m_tready_i | ~m_tvalid_o;
    assign accept     = s_tvalid_i & s_tready_o;

    // A start-of-frame beat behaves as if position state had just been cleared.
    assign x_cur       = s_tuser_i ? '0 : x_q;
    assign row_cur     = s_tuser_i ? '0 : row_vld_q;
    assign rot_cur     = s_tuser_i ? NB'(1) : rot_q;
    assign sat_cur     = sat_q & ~s_tuser_i;
    assign w_known_cur = w_known_q & ~s_tuser_i;

    assign len_cur = {1'b0, x_cur} + 1'b1;
    assign at_max  = (x_cur == XB'(MAX_W - 1));
    assign ovf     = at_max & ~s_tlast_i & ~sat_cur;
    assign len_bad = s_tlast_i & ~sat_cur & w_known_cur & (len_cur != w_q);

    for (genvar g = 0; g < NB; g++) begin : g_bank
        conv_lb_bank #(
            .DEPTH(MAX_W)
        ) u_bank (
            .clk  (clk),
            .en   (accept),
            .we   (accept & ~sat_cur & rot_cur[g]),
            .addr (x_cur),
            .wdata(s_tdata_i),
            .rdata(rd_data[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            x_q             <= '0;
            row_vld_q       <= '0;
            rot_q           <= NB'(1);
            sat_q           <= 1'b0;
            w_known_q       <= 1'b0;
            w_q             <= '0;
            m_tvalid_o      <= 1'b0;
            m_col_sol_o     <= 1'b0;
            m_col_eol_o     <= 1'b0;
            m_col_x_o       <= '0;
            m_col_row_vld_o <= '0;
            tap0_q          <= '0;
            rot_out_q       <= NB'(1);
            err_len_o       <= 1'b0;
        end else begin
            err_len_o <= accept & (ovf | len_bad);
            if (accept) begin
                if (s_tlast_i) begin
                    x_q <= '0;
                end else if (at_max) begin
                    x_q <= x_cur;
                end else begin
                    x_q <= x_cur + 1'b1;
                end
                row_vld_q <= s_tlast_i ? {row_cur[NB-2:0], 1'b1} : row_cur;
                rot_q     <= s_tlast_i ? {rot_cur[NB-2:0], rot_cur[NB-1]} : rot_cur;
                sat_q     <= ~s_tlast_i & (sat_cur | at_max);
                // An overlong line is already flagged and must not define the frame width.
                if (s_tlast_i && !sat_cur && !w_known_cur) begin
                    w_q       <= len_cur;
                    w_known_q <= 1'b1;
                end else if (s_tuser_i) begin
                    w_known_q <= 1'b0;
                end

                m_tvalid_o      <= 1'b1;
                m_col_sol_o     <= (x_cur == '0);
                m_col_eol_o     <= s_tlast_i;
                m_col_x_o       <= x_cur;
                m_col_row_vld_o <= {row_cur, 1'b1};
                tap0_q          <= s_tdata_i;
                rot_out_q       <= rot_cur;
            end else if (m_tready_i) begin
                m_tvalid_o <= 1'b0;
            end
        end
    end

    // Tap i comes from the bank i rows behind the write bank: bank j where rot[(j+i) mod NB] is set.
    always_comb begin
        m_col_data_o = '0;
        m_col_data_o[PIXEL_W-1:0] = tap0_q;
        for (int i = 1; i < K; i++) begin
            for (int j = 0; j < NB; j++) begin
                if (rot_out_q[(j + i) % NB] && m_tvalid_o && (!BORDER_ZERO || m_col_row_vld_o[i])) begin
                    m_col_data_o[i*PIXEL_W +: PIXEL_W] = m_col_data_o[i*PIXEL_W +: PIXEL_W] | rd_data[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_col_gen.sv
// tb/tb_conv_col_gen.sv - self-checking bench for conv_col_gen
module tb_conv_col_gen;
    import conv_pkg::*;

    localparam int PW = PIXEL_W;
    localparam int KA = 5;
    localparam int KB = 3;
    localparam int MW = 16;
    localparam int XBW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic            a_tvalid, a_tuser, a_tlast, a_tready, a_mvalid, a_mready, a_sol, a_eol, a_err;
    logic [PW-1:0]   a_tdata;
    logic [KA*PW-1:0] a_col;
    logic [KA-1:0]   a_rv;
    logic [XBW-1:0]  a_x;

    logic            b_tvalid, b_tuser, b_tlast, b_tready, b_mvalid, b_mready, b_sol, b_eol, b_err;
    logic [PW-1:0]   b_tdata;
    logic [KB*PW-1:0] b_col;
    logic [KB-1:0]   b_rv;
    logic [XBW-1:0]  b_x;

    conv_col_gen #(.K(KA), .MAX_W(MW), .BORDER_ZERO(1'b0)) dut_a (
        .clk(clk), .arst_n(rst_n),
        .s_tvalid_i(a_tvalid), .s_tdata_i(a_tdata), .s_tuser_i(a_tuser), .s_tlast_i(a_tlast),
        .s_tready_o(a_tready), .m_tvalid_o(a_mvalid), .m_tready_i(a_mready),
        .m_col_data_o(a_col), .m_col_row_vld_o(a_rv), .m_col_sol_o(a_sol), .m_col_eol_o(a_eol),
        .m_col_x_o(a_x), .err_len_o(a_err)
    );

    conv_col_gen #(.K(KB), .MAX_W(MW), .BORDER_ZERO(1'b1)) dut_b (
        .clk(clk), .arst_n(rst_n),
        .s_tvalid_i(b_tvalid), .s_tdata_i(b_tdata), .s_tuser_i(b_tuser), .s_tlast_i(b_tlast),
        .s_tready_o(b_tready), .m_tvalid_o(b_mvalid), .m_tready_i(b_mready),
        .m_col_data_o(b_col), .m_col_row_vld_o(b_rv), .m_col_sol_o(b_sol), .m_col_eol_o(b_eol),
        .m_col_x_o(b_x), .err_len_o(b_err)
    );

    typedef struct packed {
        logic             user;
        logic             last;
        logic [PW-1:0]    data;
        col_meta_t        meta;
        logic             err;
        logic [KA*PW-1:0] tap;
        logic [KA-1:0]    known;
    } vec_t;

    vec_t tbl [$];

    int n_cmp = 0;
    int n_bad = 0;

    int            fy;
    int            row_len [16];
    logic [PW-1:0] img [16][16];
    logic [PW-1:0] seq;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Frame-position model: expected taps come from the image rows already sent in this frame.
    task automatic add_line(input bit sof, input int n, input bit has_last, input int err_pos);
        vec_t v;
        int   x;
        if (sof) begin
            fy = 0;
            for (int r = 0; r < 16; r++) row_len[r] = 0;
        end
        for (int i = 0; i < n; i++) begin
            x = (i > MW - 1) ? MW - 1 : i;
            v = '0;
            v.user = sof && (i == 0);
            v.last = has_last && (i == n - 1);
            v.data = seq;
            seq++;
            v.meta.sol = (x == 0);
            v.meta.eol = v.last;
            v.meta.x = XW'(x);
            v.meta.row_vld[0] = 1'b1;
            v.tap[PW-1:0] = v.data;
            v.known[0] = 1'b1;
            for (int k = 1; k < KA; k++) begin
                if (fy >= k) begin
                    v.meta.row_vld[k] = 1'b1;
                    if (x < row_len[fy-k]) begin
                        v.known[k] = 1'b1;
                        v.tap[k*PW +: PW] = img[fy-k][x];
                    end
                end
            end
            v.err = (i == err_pos);
            if (i < MW) img[fy][x] = v.data;
            tbl.push_back(v);
        end
        if (has_last) begin
            row_len[fy] = (n > MW) ? MW : n;
            fy++;
        end
    endtask

    bit mon_en = 0;
    bit rnd_ready = 0;
    bit prev_acc = 0;
    bit prev_stall = 0;
    int acc_idx = 0;
    logic [KA*PW-1:0] snap_col;
    logic [KA-1:0]    snap_rv;
    logic [XBW-1:0]   snap_x;
    logic             snap_sol, snap_eol;

    task automatic check_out(input vec_t v, input int idx);
        col_meta_t        act;
        logic [KA*PW-1:0] mask;
        act = '0;
        act.sol = a_sol;
        act.eol = a_eol;
        act.x = XW'(a_x);
        act.row_vld = KMAX'(a_rv);
        mask = '0;
        for (int k = 0; k < KA; k++) mask[k*PW +: PW] = {PW{v.known[k]}};
        chk($sformatf("tvalid[%0d]", idx), 64'(a_mvalid), 64'(1));
        chk($sformatf("meta[%0d]", idx), 64'(act), 64'(v.meta));
        chk($sformatf("taps[%0d]", idx), 64'(a_col & mask), 64'(v.tap & mask));
        chk($sformatf("err_len[%0d]", idx), 64'(a_err), 64'(v.err));
        if (idx == 35) begin
            chk("col_x3_y4", 64'(a_col), 64'({8'd3, 8'd11, 8'd19, 8'd27, 8'd35}));
            chk("rv_x3_y4", 64'(a_rv), 64'(5'b11111));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_acc) begin
                if (acc_idx < tbl.size()) check_out(tbl[acc_idx], acc_idx);
                else chk("extra_output", 64'(acc_idx), 64'(tbl.size() - 1));
                acc_idx++;
            end else begin
                chk("err_idle", 64'(a_err), 64'(0));
            end
            if (prev_stall) begin
                chk("stall_hold", {a_mvalid, a_rv, a_x, a_sol, a_eol, a_col[22:0]},
                    {1'b1, snap_rv, snap_x, snap_sol, snap_eol, snap_col[22:0]});
                chk("stall_hold_hi", 64'(a_col[39:23]), 64'(snap_col[39:23]));
            end
            prev_acc   = a_tvalid & a_tready;
            prev_stall = a_mvalid & ~a_mready;
            snap_col = a_col;
            snap_rv  = a_rv;
            snap_x   = a_x;
            snap_sol = a_sol;
            snap_eol = a_eol;
        end else begin
            prev_acc   = 0;
            prev_stall = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) a_mready = 1'($urandom_range(0, 1));
    end

    task automatic run_pass(input bit gaps);
        int guard;
        bit acc;
        acc_idx = 0;
        a_mready = 1'b1;
        mon_en = 1;
        rnd_ready = gaps;
        for (int n = 0; n < tbl.size(); n++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            a_tdata = tbl[n].data;
            a_tuser = tbl[n].user;
            a_tlast = tbl[n].last;
            a_tvalid = 1'b1;
            guard = 0;
            acc = 0;
            while (!acc && guard < 100) begin
                @(negedge clk);
                acc = a_tready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) chk("accept_timeout", 64'(guard), 64'(0));
            a_tvalid = 1'b0;
        end
        rnd_ready = 0;
        a_mready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        mon_en = 0;
        chk(gaps ? "count_gapped" : "count_gapfree", 64'(acc_idx), 64'(tbl.size()));
    endtask

    task automatic a_beat(input logic u, input logic l, input logic [PW-1:0] d);
        a_tuser = u;
        a_tlast = l;
        a_tdata = d;
        a_tvalid = 1'b1;
        @(posedge clk);
        #1;
        a_tvalid = 1'b0;
        a_tuser = 1'b0;
        a_tlast = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0] d, prev;
        rst_n = 0;
        a_tvalid = 0; a_tuser = 0; a_tlast = 0; a_tdata = '0; a_mready = 1;
        b_tvalid = 0; b_tuser = 0; b_tlast = 0; b_tdata = '0; b_mready = 1;

        seq = '0;
        for (int y = 0; y < 5; y++) add_line(y == 0, 8, 1, -1);
        add_line(1, 8, 1, -1);
        add_line(0, 8, 1, -1);
        add_line(0, 7, 1, 6);
        add_line(0, 8, 1, -1);
        add_line(0, 20, 1, 15);
        add_line(0, 16, 1, 15);
        add_line(0, 8, 1, -1);
        add_line(1, 8, 1, -1);
        add_line(0, 8, 1, -1);
        add_line(0, 5, 0, -1);
        add_line(1, 8, 1, -1);
        add_line(0, 8, 1, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_a_outputs", 64'({a_mvalid, a_rv, a_sol, a_eol, a_x, a_err}), 64'(0));
        chk("reset_a_col", 64'(a_col), 64'(0));
        chk("reset_a_tready", 64'(a_tready), 64'(1));
        chk("reset_b_outputs", 64'({b_mvalid, b_col, b_rv, b_sol, b_eol, b_x, b_err}), 64'(0));
        rst_n = 1;
        @(posedge clk);
        #1;

        // K=3 with zeroed border: first line sees only tap 0, second line adds tap 1.
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 0; i < 4; i++) begin
                d = (ln == 0 ? 8'hA0 : 8'hB0) + 8'(i);
                prev = 8'hA0 + 8'(i);
                b_tdata = d;
                b_tuser = (ln == 0) && (i == 0);
                b_tlast = (i == 3);
                b_tvalid = 1'b1;
                @(posedge clk);
                #1;
                chk($sformatf("b_rv[%0d.%0d]", ln, i), 64'(b_rv), 64'(ln == 0 ? 3'b001 : 3'b011));
                chk($sformatf("b_col[%0d.%0d]", ln, i), 64'(b_col),
                    64'(ln == 0 ? {16'h0000, d} : {8'h00, prev, d}));
            end
        end
        b_tvalid = 1'b0;

        run_pass(1'b0);
        run_pass(1'b1);

        a_mready = 1'b1;
        a_beat(1'b1, 1'b0, 8'h11);
        chk("lat1_valid", 64'(a_mvalid), 64'(1));
        chk("lat1_x_sol", 64'({a_x, a_sol}), 64'({4'd0, 1'b1}));
        a_beat(1'b0, 1'b0, 8'h12);
        chk("second_x", 64'(a_x), 64'(1));
        rst_n = 0;
        @(posedge clk);
        #1;
        chk("midreset_outputs", 64'({a_mvalid, a_rv, a_sol, a_eol, a_x, a_err}), 64'(0));
        chk("midreset_col", 64'(a_col), 64'(0));
        rst_n = 1;

        a_beat(1'b0, 1'b0, 8'h55);
        chk("post_rst_meta", 64'({a_mvalid, a_x, a_sol, a_eol, a_rv}), 64'({1'b1, 4'd0, 1'b1, 1'b0, 5'b00001}));
        chk("post_rst_tap0", 64'(a_col[7:0]), 64'(8'h55));
        a_beat(1'b0, 1'b1, 8'h56);
        chk("post_rst_eol", 64'({a_x, a_sol, a_eol, a_rv, a_err}), 64'({4'd1, 1'b0, 1'b1, 5'b00001, 1'b0}));
        a_beat(1'b0, 1'b0, 8'h57);
        chk("post_rst_row1", 64'({a_x, a_rv}), 64'({4'd0, 5'b00011}));
        chk("post_rst_tap1", 64'(a_col[15:0]), 64'({8'h55, 8'h57}));
        a_beat(1'b0, 1'b1, 8'h58);
        chk("post_rst_len_ok", 64'({a_x, a_eol, a_err}), 64'({4'd1, 1'b1, 1'b0}));
        a_beat(1'b1, 1'b1, 8'h60);
        chk("single_px", 64'({a_x, a_sol, a_eol, a_rv, a_err}), 64'({4'd0, 1'b1, 1'b1, 5'b00001, 1'b0}));
        a_beat(1'b0, 1'b1, 8'h61);
        chk("single_px_row1", 64'({a_x, a_sol, a_eol, a_rv, a_err}), 64'({4'd0, 1'b1, 1'b1, 5'b00011, 1'b0}));
        chk("single_px_tap1", 64'(a_col[15:0]), 64'({8'h60, 8'h61}));
        @(posedge clk);
        #1;
        chk("drain_valid", 64'(a_mvalid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
